// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, lane masks and read-pipeline stage type for the SRAM responder.
package sram_pkg;
    localparam int SRAM_ADDR_W = 19;
    localparam int SRAM_DATA_W = 32;
    localparam logic [SRAM_DATA_W-1:0] UB_MASK = 32'hFFFF_0000;
    localparam logic [SRAM_DATA_W-1:0] LB_MASK = 32'h0000_FFFF;

    typedef struct packed {
        logic                   valid;
        logic [SRAM_DATA_W-1:0] data;
    } rd_stage_t;

    function automatic logic [SRAM_DATA_W-1:0] lane_mask(input logic ub_n, input logic lb_n);
        return (ub_n ? '0 : UB_MASK) | (lb_n ? '0 : LB_MASK);
    endfunction
endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: SRAM controller strobes/address plus responder status.
// Statistics signals exist only when SRAM_RESPONDER_STATS_EN is defined.
interface sram_responder_if;
    logic [sram_pkg::SRAM_ADDR_W-1:0] SRAM_Addr;
    logic SRAM_UB_N;
    logic SRAM_LB_N;
    logic SRAM_WE_N;
    logic SRAM_CE_N;
    logic SRAM_OE_N;
    logic rd_valid;
`ifdef SRAM_RESPONDER_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic oob_err;
    modport master (output SRAM_Addr, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
                    input rd_valid, rd_count, wr_count, oob_err);
    modport slave (input SRAM_Addr, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
                   output rd_valid, rd_count, wr_count, oob_err);
`else
    modport master (output SRAM_Addr, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
                    input rd_valid);
    modport slave (input SRAM_Addr, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
                   output rd_valid);
`endif
endinterface

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: READ_LATENCY-deep shift register of {valid, data}, cleared by sync reset.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  rd_stage_t in_i,
    output rd_stage_t out_o
);
    rd_stage_t stage_q [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < READ_LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_o = stage_q[READ_LATENCY-1];
endmodule

// File: rtl/sram_responder.sv
// sram_responder: clocked model of a 32-bit external SRAM with byte-lane writes and pipelined reads.
// Optional access statistics are enabled by defining SRAM_RESPONDER_STATS_EN.
module sram_responder
    import sram_pkg::*;
#(
    parameter int DEPTH        = 65536,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    inout  wire [SRAM_DATA_W-1:0]  SRAM_DQ,
    sram_responder_if.slave        bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [SRAM_DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic                   in_range;
    logic                   wr_en;
    logic                   rd_en;
    logic [IDX_W-1:0]       idx;
    logic [SRAM_DATA_W-1:0] mask;
    rd_stage_t              rd_in;
    rd_stage_t              rd_out;

    // Range check uses all 19 address bits before truncating to the array index.
    assign in_range = 32'(bus.SRAM_Addr) < 32'(DEPTH);
    assign idx      = bus.SRAM_Addr[IDX_W-1:0];
    assign wr_en    = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
    assign rd_en    = !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
    assign mask     = lane_mask(bus.SRAM_UB_N, bus.SRAM_LB_N);

    always_ff @(posedge clk) begin
        if (!rst && wr_en && in_range) mem[idx] <= (mem[idx] & ~mask) | (SRAM_DQ & mask);
    end

    assign rd_in.valid = rd_en;
    assign rd_in.data  = (rd_en && in_range) ? (mem[idx] & mask) : '0;

    sram_rd_pipe #(.READ_LATENCY(READ_LATENCY)) u_rd_pipe (
        .clk  (clk),
        .rst  (rst),
        .in_i (rd_in),
        .out_o(rd_out)
    );

    // Drive only during a read-strobed cycle so a controller write never contends.
    assign SRAM_DQ      = (rd_out.valid && !bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N) ? rd_out.data : 'z;
    assign bus.rd_valid = rd_out.valid;

`ifdef SRAM_RESPONDER_STATS_EN
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;
    logic        oob_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
            oob_q      <= 1'b0;
        end else begin
            if (rd_en && rd_count_q != '1) rd_count_q <= rd_count_q + 32'd1;
            if (wr_en && wr_count_q != '1) wr_count_q <= wr_count_q + 32'd1;
            if ((rd_en || wr_en) && !in_range) oob_q <= 1'b1;
        end
    end

    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;
    assign bus.oob_err  = oob_q;
`endif
endmodule
